mac_dot_sequencer: RTL

Upstream feeder for the MAC accumulator. It buffers (A,B) operand pairs in an internal FIFO. On start, it clears the MAC, then streams exactly VEC_LEN pairs into it, one per cycle when data is available. It pulses done in the first cycle in which the MAC's Cout holds the complete dot product.

---
 rtl/mac_dot_sequencer_if.sv | 47 ++++
 rtl/mac_dot_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_dot_sequencer_if
//  Purpose  : Bundles the operand push port, the FIFO status flags, the
//             start/busy/done control handshake and the MAC drive bus of the
//             dot-product sequencer.
//  Modports : master - the feeding/controlling agent (drives pushes, start)
//             slave  - the sequencer itself
//  Signals  : wr_en, a_in, b_in          operand pair push
//             full, empty, fifo_count    FIFO occupancy
//             overflow                   sticky dropped-push flag
//             start, busy, done          dot-product control
//             mac_en, mac_clr, mac_a/b   MAC accumulator drive
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_dot_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   a_in;
    logic [DATA_WIDTH-1:0]   b_in;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    mac_en;
    logic                    mac_clr;
    logic [DATA_WIDTH-1:0]   mac_a;
    logic [DATA_WIDTH-1:0]   mac_b;

    modport master (
        output wr_en, a_in, b_in, start,
        input  full, empty, fifo_count, overflow,
        input  busy, done, mac_en, mac_clr, mac_a, mac_b
    );

    modport slave (
        input  wr_en, a_in, b_in, start,
        output full, empty, fifo_count, overflow,
        output busy, done, mac_en, mac_clr, mac_a, mac_b
    );
endinterface
`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_dot_sequencer
//  Purpose  : Upstream feeder for a MAC accumulator. Buffers (A,B) operand
//             pairs in a circular FIFO; on start it clears the MAC for one
//             cycle, streams VEC_LEN pairs into it (stalling while the FIFO
//             is empty) and pulses done when the MAC output is final.
//  Ports    : clk    - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - mac_dot_sequencer_if.slave (push port, FIFO status,
//                      start/busy/done, registered MAC drive)
//  Revision : 1.0 - initial release
// ============================================================================
module mac_dot_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int VEC_LEN    = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mac_dot_sequencer_if.slave     bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int VCNT_W = $clog2(VEC_LEN + 1);

    localparam logic [CNT_W-1:0]  c_full_cnt  = CNT_W'(DEPTH);
    localparam logic [VCNT_W-1:0] c_last_pair = VCNT_W'(VEC_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [2*DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic                      r_overflow;
    logic [VCNT_W-1:0]         r_pair_cnt;
    logic                      r_mac_en;
    logic                      r_mac_clr;
    logic [DATA_WIDTH-1:0]     r_mac_a;
    logic [DATA_WIDTH-1:0]     r_mac_b;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.wr_en && !w_full;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.a_in, bus.b_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A push against a full FIFO is dropped even if a pop frees a
            // slot on the same edge.
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The edge leaving CLEAR already pops, so the first pair reaches the MAC
    // in the cycle right after the clear and done lands VEC_LEN+2 cycles
    // after start.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR, S_RUN: begin
                w_pop = !w_empty;
                if (w_pop && (r_pair_cnt == c_last_pair)) begin
                    w_next_state = S_FLUSH;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_FLUSH: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Pair counter sits at zero whenever idle, so it is zero on entry to CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_pair_cnt <= '0;
        end else if (w_pop) begin
            r_pair_cnt <= r_pair_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered MAC drive
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
            r_mac_a   <= '0;
            r_mac_b   <= '0;
        end else begin
            r_mac_en  <= w_pop;
            r_mac_clr <= (w_next_state == S_CLEAR);
            if (w_pop) begin
                {r_mac_a, r_mac_b} <= r_mem[r_rd_ptr];
            end else if (w_next_state == S_IDLE) begin
                // Operand lines rest at zero while idle; during a stall they hold.
                r_mac_a <= '0;
                r_mac_b <= '0;
            end
        end
    end

    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.mac_en     = r_mac_en;
    assign bus.mac_clr    = r_mac_clr;
    assign bus.mac_a      = r_mac_a;
    assign bus.mac_b      = r_mac_b;

endmodule
`default_nettype wire
